// File: rtl/round_key_store_ctrl.sv
// Round-key store controller: runs one AES-256 key schedule, captures its
// round keys and serves indexed reads to the encrypt and decrypt cores.
module round_key_store_ctrl #(
    parameter int NUM_RK       = 15,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [0:255] key_in,
    output logic         sched_start,
    output logic [0:255] sched_key,
    input  logic         sched_valid,
    input  logic [0:127] sched_rk,
    output logic         keys_ready,
    output logic         sched_error,
    input  logic         enc_req,
    input  logic [3:0]   enc_idx,
    output logic         enc_gnt,
    input  logic         dec_req,
    input  logic [3:0]   dec_idx,
    output logic         dec_gnt,
    output logic         rk_valid,
    output logic         rk_owner,
    output logic [0:127] rk_out,
    output logic         rk_idx_err
);

    // Handshakes: key_in transfers on key_in_valid & key_in_ready. Read
    // requests are held high until the matching combinational grant; data
    // follows one cycle after the grant with rk_valid high for one cycle.

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_START,
        ST_LOAD,
        ST_DRAIN,
        ST_READY
    } state_t;

    localparam int CW = $clog2(NUM_RK + 1);
    localparam int TW = $clog2(LOAD_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_RK - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOAD_TIMEOUT - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(1);
    localparam logic [3:0]    IDX_MAX = 4'(NUM_RK - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ptr_q, ptr_d;
    logic [0:255]   key_q, key_d;
    logic           err_q, err_d;
    logic           rdv_q, rdv_d;
    logic           own_q, own_d;
    logic [0:127]   out_q, out_d;
    logic           ierr_q, ierr_d;
    logic [0:127]   store_q [NUM_RK];

    logic           accept;
    logic           arb_en;
    logic           wr_en;
    logic [3:0]     rd_idx;
    logic [3:0]     rd_addr;
    logic           rd_bad;
    logic [0:127]   rd_data;

    assign key_in_ready = (state_q == ST_EMPTY) || (state_q == ST_READY);
    assign accept       = key_in_valid && key_in_ready;
    assign sched_start  = (state_q == ST_START);
    assign keys_ready   = (state_q == ST_READY);
    assign sched_key    = key_q;
    assign sched_error  = err_q;

    // A key accepted in READY takes priority; no read is granted that cycle.
    assign arb_en  = (state_q == ST_READY) && !accept;
    assign enc_gnt = arb_en && enc_req && (!dec_req || ptr_q);
    assign dec_gnt = arb_en && dec_req && (!enc_req || !ptr_q);

    // Decrypt indices count down from the last round key.
    assign rd_idx  = enc_gnt ? enc_idx : dec_idx;
    assign rd_bad  = (rd_idx > IDX_MAX);
    assign rd_addr = enc_gnt ? enc_idx : (IDX_MAX - dec_idx);

    always_comb begin
        rd_data = '0;
        if (!rd_bad) begin
            rd_data = store_q[rd_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        key_d   = key_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_EMPTY, ST_READY: begin
                if (accept) begin
                    state_d = ST_START;
                    key_d   = key_in;
                    err_d   = 1'b0;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (sched_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                if (sched_valid && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DRAIN;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_EMPTY;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Two cycles for the scheduler to settle back to idle.
                if (tmo_q == DRAIN_LAST) begin
                    state_d = ST_READY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        rdv_d  = enc_gnt || dec_gnt;
        own_d  = own_q;
        out_d  = out_q;
        ierr_d = 1'b0;
        ptr_d  = ptr_q;
        if (enc_gnt || dec_gnt) begin
            own_d  = dec_gnt;
            out_d  = rd_data;
            ierr_d = rd_bad;
            ptr_d  = dec_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            tmo_q   <= '0;
            ptr_q   <= 1'b1;
            key_q   <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            own_q   <= 1'b0;
            out_q   <= '0;
            ierr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            key_q   <= key_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            own_q   <= own_d;
            out_q   <= out_d;
            ierr_q  <= ierr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_q[cnt_q] <= sched_rk;
        end
    end

    assign rk_valid   = rdv_q;
    assign rk_owner   = own_q;
    assign rk_out     = out_q;
    assign rk_idx_err = ierr_q;

endmodule

// File: tb/tb_round_key_store_ctrl.sv
// Directed bench for round_key_store_ctrl: load, reads, arbitration,
// reload-in-READY, load timeout and reset during LOAD.
module tb_round_key_store_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_in_valid;
    logic         key_in_ready;
    logic [0:255] key_in;
    logic         sched_start;
    logic [0:255] sched_key;
    logic         sched_valid;
    logic [0:127] sched_rk;
    logic         keys_ready;
    logic         sched_error;
    logic         enc_req;
    logic [3:0]   enc_idx;
    logic         enc_gnt;
    logic         dec_req;
    logic [3:0]   dec_idx;
    logic         dec_gnt;
    logic         rk_valid;
    logic         rk_owner;
    logic [0:127] rk_out;
    logic         rk_idx_err;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B = 256'hffeeddccbbaa99887766554433221100ffeeddccbbaa99887766554433221100;
    localparam logic [127:0] MASK_B = {16{8'h5a}};

    round_key_store_ctrl dut (
        .clk(clk), .rst(rst),
        .key_in_valid(key_in_valid), .key_in_ready(key_in_ready), .key_in(key_in),
        .sched_start(sched_start), .sched_key(sched_key),
        .sched_valid(sched_valid), .sched_rk(sched_rk),
        .keys_ready(keys_ready), .sched_error(sched_error),
        .enc_req(enc_req), .enc_idx(enc_idx), .enc_gnt(enc_gnt),
        .dec_req(dec_req), .dec_idx(dec_idx), .dec_gnt(dec_gnt),
        .rk_valid(rk_valid), .rk_owner(rk_owner), .rk_out(rk_out),
        .rk_idx_err(rk_idx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sched_start === 1'b1) start_cnt++;
    end

    // Scheduler model: keys 0/1 are the cipher key halves, key 14 is the
    // known last AES-256 round key; the rest are distinct filler patterns.
    function automatic logic [127:0] rk_val(input int i, input logic [127:0] mask);
        logic [127:0] v;
        case (i)
            0:       v = 128'h000102030405060708090a0b0c0d0e0f;
            1:       v = 128'h101112131415161718191a1b1c1d1e1f;
            14:      v = 128'h24fc79ccbf0979e9371ac23c6d68de36;
            default: v = {16{8'(160 + i)}};
        endcase
        return v ^ mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int n, input logic [127:0] mask);
        for (int i = 0; i < n; i++) begin
            sched_valid = 1'b1;
            sched_rk    = rk_val(i, mask);
            tick();
        end
        sched_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_in_valid = 1'b0;
        key_in = '0;
        sched_valid = 1'b0;
        sched_rk = '0;
        enc_req = 1'b0;
        enc_idx = '0;
        dec_req = 1'b0;
        dec_idx = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_key_in_ready", key_in_ready, 1);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_sched_start", sched_start, 0);
        chk("rst_sched_error", sched_error, 0);
        chk("rst_sched_key", sched_key, 0);
        chk("rst_rk_valid", rk_valid, 0);
        chk("rst_rk_out", rk_out, 0);
        chk("rst_enc_gnt", enc_gnt, 0);
        rst = 1'b0;
        tick();

        // Load key A
        key_in_valid = 1'b1;
        key_in = KEY_A;
        #1;
        chk("load_ready_empty", key_in_ready, 1);
        tick();
        key_in_valid = 1'b0;
        chk("start_pulse", sched_start, 1);
        chk("start_key", sched_key, KEY_A);
        chk("start_not_ready", key_in_ready, 0);
        tick();
        chk("load_start_low", sched_start, 0);
        feed(15, '0);
        chk("drain1_keys_ready", keys_ready, 0);
        tick();
        chk("drain2_keys_ready", keys_ready, 0);
        tick();
        chk("ready_keys_ready", keys_ready, 1);
        chk("start_once", start_cnt, 1);

        // Encryption reads idx 0 and 1
        enc_req = 1'b1;
        enc_idx = 4'd0;
        #1;
        chk("enc0_gnt", enc_gnt, 1);
        chk("enc0_no_dec_gnt", dec_gnt, 0);
        tick();
        enc_idx = 4'd1;
        chk("enc0_valid", rk_valid, 1);
        chk("enc0_owner", rk_owner, 0);
        chk("enc0_out", rk_out, rk_val(0, '0));
        chk("enc0_err", rk_idx_err, 0);
        #1;
        chk("enc1_gnt", enc_gnt, 1);
        tick();
        enc_req = 1'b0;
        chk("enc1_out", rk_out, rk_val(1, '0));
        tick();
        chk("idle_valid", rk_valid, 0);
        chk("idle_hold_out", rk_out, rk_val(1, '0));

        // Decryption read idx 0 -> store[14]
        dec_req = 1'b1;
        dec_idx = 4'd0;
        #1;
        chk("dec0_gnt", dec_gnt, 1);
        chk("dec0_no_enc_gnt", enc_gnt, 0);
        tick();
        dec_req = 1'b0;
        chk("dec0_valid", rk_valid, 1);
        chk("dec0_owner", rk_owner, 1);
        chk("dec0_out", rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Both requesting: alternate starting with encryption
        enc_req = 1'b1;
        enc_idx = 4'd2;
        dec_req = 1'b1;
        dec_idx = 4'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_enc_gnt", enc_gnt, (k % 2) == 0);
            chk("rr_dec_gnt", dec_gnt, (k % 2) == 1);
            tick();
            chk("rr_owner", rk_owner, (k % 2) == 1);
            chk("rr_out", rk_out, ((k % 2) == 0) ? rk_val(2, '0) : rk_val(11, '0));
        end
        enc_req = 1'b0;
        dec_req = 1'b0;
        tick();

        // In-flight read, then key B accepted in READY with enc_req pending
        enc_req = 1'b1;
        enc_idx = 4'd5;
        #1;
        chk("inflight_gnt", enc_gnt, 1);
        tick();
        key_in_valid = 1'b1;
        key_in = KEY_B;
        enc_idx = 4'd15;
        chk("inflight_valid", rk_valid, 1);
        chk("inflight_old_data", rk_out, rk_val(5, '0));
        #1;
        chk("accept_ready", key_in_ready, 1);
        chk("accept_no_gnt", enc_gnt, 0);
        tick();
        key_in_valid = 1'b0;
        chk("reload_keys_ready", keys_ready, 0);
        chk("reload_no_valid", rk_valid, 0);
        chk("reload_start", sched_start, 1);
        chk("reload_key", sched_key, KEY_B);
        chk("reload_start_no_gnt", enc_gnt, 0);
        tick();
        feed(15, MASK_B);
        tick();
        tick();
        chk("reload_ready", keys_ready, 1);
        chk("held_req_gnt", enc_gnt, 1);
        tick();
        enc_idx = 4'd0;
        chk("idx15_valid", rk_valid, 1);
        chk("idx15_err", rk_idx_err, 1);
        chk("idx15_out", rk_out, 0);
        #1;
        chk("newkey_gnt", enc_gnt, 1);
        tick();
        enc_req = 1'b0;
        chk("newkey_out", rk_out, rk_val(0, MASK_B));
        chk("newkey_err", rk_idx_err, 0);

        // Load timeout after 10 strobes
        key_in_valid = 1'b1;
        key_in = KEY_A;
        tick();
        key_in_valid = 1'b0;
        tick();
        feed(10, '0);
        repeat (53) tick();
        chk("tmo_cycle63_busy", key_in_ready, 0);
        chk("tmo_cycle63_err", sched_error, 0);
        tick();
        chk("tmo_err", sched_error, 1);
        chk("tmo_keys_ready", keys_ready, 0);
        chk("tmo_empty", key_in_ready, 1);
        key_in_valid = 1'b1;
        tick();
        key_in_valid = 1'b0;
        chk("tmo_err_cleared", sched_error, 0);
        chk("tmo_restart", sched_start, 1);

        // Reset during LOAD after 7 strobes
        tick();
        feed(7, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_empty", key_in_ready, 1);
        chk("mid_rst_keys_ready", keys_ready, 0);
        chk("mid_rst_key", sched_key, 0);
        chk("mid_rst_start", sched_start, 0);
        sched_valid = 1'b1;
        sched_rk = rk_val(7, '0);
        repeat (3) tick();
        sched_valid = 1'b0;
        chk("stray_strobe_empty", key_in_ready, 1);
        chk("stray_strobe_keys_ready", keys_ready, 0);
        chk("stray_strobe_start", sched_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
